// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared definitions for the I2C transaction arbiter: FSM state encoding,
// watchdog counter width and slave address width.
package i2c_txn_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    localparam int WDOG_W = 16;
    localparam int ADDR_W = 7;

endpackage

// File: rtl/i2c_txn_arbiter_rr_select.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ... (mod N_REQ) and
// returns the first pending requester as one-hot, index and valid.
module i2c_txn_arbiter_rr_select
    import i2c_txn_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    // first set request after the pointer wins; the pointer itself is scanned last
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C core transaction port among N_REQ
// requesters. All outputs are registered and clear on bus_rst_i.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort transactions whose
// core never reports done within TIMEOUT cycles of waiting.
module i2c_txn_arbiter
    import i2c_txn_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int LEN_WIDTH = 8,
    parameter int TIMEOUT   = 65535
) (
    input  logic                       bus_clk_i,
    input  logic                       bus_rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [ADDR_W*N_REQ-1:0]    req_addr_i,
    input  logic [N_REQ-1:0]           req_rw_i,
    input  logic [LEN_WIDTH*N_REQ-1:0] req_len_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [N_REQ-1:0]           done_o,
    output logic [N_REQ-1:0]           err_o,
    output logic                       core_start_o,
    output logic [ADDR_W-1:0]          core_addr_o,
    output logic                       core_rw_o,
    output logic [LEN_WIDTH-1:0]       core_len_o,
    input  logic                       core_done_i,
    input  logic                       core_nack_i,
    output logic                       core_abort_o
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [N_REQ-1:0]     err_q, err_d;
    logic                 start_q, start_d;
    logic                 abort_q, abort_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;

    logic [N_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 wdog_expired;

    i2c_txn_arbiter_rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    logic [WDOG_W-1:0] wdog_q;

    // watchdog: cleared while issuing, counts every cycle spent waiting on the core
    always_ff @(posedge bus_clk_i or posedge bus_rst_i) begin
        if (bus_rst_i) begin
            wdog_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wdog_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign wdog_expired = (state_q == ST_WAIT) && (wdog_q == WDOG_LAST);
`else
    localparam int unused_timeout = TIMEOUT;
    assign wdog_expired = 1'b0;
`endif

    // state register
    always_ff @(posedge bus_clk_i or posedge bus_rst_i) begin
        if (bus_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: a core done takes priority over a same-cycle watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (core_done_i || wdog_expired) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // output/datapath next values; registered so they appear the cycle after the decision
    always_comb begin
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
        abort_d = 1'b0;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    gnt_d   = pick_onehot;
                    start_d = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_onehot[i]) begin
                            addr_d = req_addr_i[i*ADDR_W +: ADDR_W];
                            rw_d   = req_rw_i[i];
                            len_d  = req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (core_done_i) begin
                    gnt_d  = '0;
                    done_d = gnt_q;
                    err_d  = core_nack_i ? gnt_q : '0;
                    ptr_d  = sel_q;
                end else if (wdog_expired) begin
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    abort_d = 1'b1;
                    ptr_d   = sel_q;
                end
            end
            default: ;
        endcase
    end

    // output and field registers; pointer resets so requester 0 is scanned first
    always_ff @(posedge bus_clk_i or posedge bus_rst_i) begin
        if (bus_rst_i) begin
            ptr_q   <= IDX_W'(N_REQ - 1);
            sel_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            len_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign core_start_o = start_q;
    assign core_abort_o = abort_q;
    assign core_addr_o  = addr_q;
    assign core_rw_o    = rw_q;
    assign core_len_o   = len_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed scenarios followed by
// randomized transactions compared against a round-robin reference model.
module tb_i2c_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [3:0]  req_rw;
    logic [31:0] req_len;
    logic [3:0]  gnt, done, err;
    logic        core_start, core_rw, core_abort;
    logic [6:0]  core_addr;
    logic [7:0]  core_len;
    logic        core_done, core_nack;

    logic [6:0]  a_addr [4];
    logic [7:0]  a_len  [4];

    int checks      = 0;
    int failures    = 0;
    int mptr        = 3;
    int exp_dones   = 0;
    int done_seen   = 0;
    int onehot_viol = 0;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(
        .N_REQ     (4),
        .LEN_WIDTH (8),
        .TIMEOUT   (100)
    ) dut (
        .bus_clk_i    (clk),
        .bus_rst_i    (rst),
        .req_i        (req),
        .req_addr_i   (req_addr),
        .req_rw_i     (req_rw),
        .req_len_i    (req_len),
        .gnt_o        (gnt),
        .done_o       (done),
        .err_o        (err),
        .core_start_o (core_start),
        .core_addr_o  (core_addr),
        .core_rw_o    (core_rw),
        .core_len_o   (core_len),
        .core_done_i  (core_done),
        .core_nack_i  (core_nack),
        .core_abort_o (core_abort)
    );

    always_comb begin
        req_addr = '0;
        req_len  = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*7 +: 7] = a_addr[i];
            req_len[i*8 +: 8]  = a_len[i];
        end
    end

    always @(negedge clk) begin
        if (!$onehot0(gnt)) onehot_viol++;
        done_seen += $countones(done);
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    // Reference: first pending requester scanning ptr+1, ptr+2, ... mod 4.
    function automatic int rr_pick(input logic [3:0] m, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input int idx, input bit nack, input int dly,
                           input bit drop_mid, input bit mutate, input bit keep_req);
        logic [3:0] oh;
        logic [6:0] e_addr;
        logic       e_rw;
        logic [7:0] e_len;
        int         n;
        oh     = 4'(1 << idx);
        e_addr = a_addr[idx];
        e_rw   = req_rw[idx];
        e_len  = a_len[idx];
        n      = 0;
        while (gnt === 4'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("grant", 32'(gnt), 32'(oh));
        check("start", 32'(core_start), 32'd1);
        check("core_fields", {16'd0, core_addr, core_rw, core_len}, {16'd0, e_addr, e_rw, e_len});
        @(negedge clk);
        check("start_pulse", 32'(core_start), 32'd0);
        if (drop_mid) req = 4'b0;
        if (mutate) begin
            a_addr[idx] = ~a_addr[idx];
            a_len[idx]  = a_len[idx] + 8'd1;
            req_rw[idx] = ~req_rw[idx];
        end
        repeat (dly - 1) @(negedge clk);
        check("gnt_held", 32'(gnt), 32'(oh));
        check("fields_held", {16'd0, core_addr, core_rw, core_len}, {16'd0, e_addr, e_rw, e_len});
        core_done = 1'b1;
        core_nack = nack;
        @(negedge clk);
        check("done", 32'(done), 32'(oh));
        check("err", 32'(err), nack ? 32'(oh) : 32'd0);
        check("gnt_release", 32'(gnt), 32'd0);
        core_done = 1'b0;
        core_nack = 1'b0;
        if (!keep_req) req = 4'b0;
        mptr = idx;
        exp_dones++;
        @(negedge clk);
        check("done_pulse", {24'd0, done, err}, 32'd0);
    endtask

    initial begin
        int order [5];
        int n;
        logic [3:0] mask;
        order = '{0, 1, 2, 3, 0};

        rst = 1'b1; req = 4'b0; req_rw = 4'b0;
        core_done = 1'b0; core_nack = 1'b0;
        for (int i = 0; i < 4; i++) begin a_addr[i] = '0; a_len[i] = '0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", {2'd0, gnt, done, err, core_start, core_addr, core_rw, core_len, core_abort}, 32'd0);
        rst = 1'b0;

        // idle with no requests
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_outputs", {2'd0, gnt, done, err, core_start, core_addr, core_rw, core_len, core_abort}, 32'd0);
        end

        // single write to 0x49, 3 bytes
        a_addr[2] = 7'h49; req_rw[2] = 1'b0; a_len[2] = 8'd3; req = 4'b0100;
        run_txn(2, 1'b0, 5, 1'b0, 1'b0, 1'b0);

        // stray core done while idle is ignored
        core_done = 1'b1; core_nack = 1'b1;
        @(negedge clk);
        core_done = 1'b0; core_nack = 1'b0;
        check("stray_done", {20'd0, done, err, gnt}, 32'd0);

        // all requesting from reset: order 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mptr = 3;
        for (int i = 0; i < 4; i++) begin
            a_addr[i] = 7'($urandom); a_len[i] = 8'($urandom); req_rw[i] = 1'($urandom);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) run_txn(order[k], 1'b0, 10, k == 4, 1'b0, 1'b1);

        // read with NACK, then pointer must sit on 1
        a_addr[1] = 7'h22; req_rw[1] = 1'b1; a_len[1] = 8'd2; req = 4'b0010;
        run_txn(1, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        req = 4'b0011;
        run_txn(rr_pick(4'b0011, mptr), 1'b0, 3, 1'b0, 1'b0, 1'b0);
        check("ptr_after_nack", 32'(mptr), 32'd0);

        // reset during WAIT
        req = 4'b0010; n = 0;
        while (gnt === 4'b0 && n < 30) begin @(negedge clk); n++; end
        check("rst_pre_grant", 32'(gnt), 32'b0010);
        @(negedge clk);
        @(negedge clk);
        core_done = 1'b1; rst = 1'b1;
        #1;
        check("rst_gnt_clear", {19'd0, gnt, done, err, core_start}, 32'd0);
        @(negedge clk);
        check("rst_no_done", {19'd0, done, err, gnt, core_abort}, 32'd0);
        rst = 1'b0; core_done = 1'b0; mptr = 3;
        run_txn(rr_pick(req, mptr), 1'b0, 3, 1'b0, 1'b0, 1'b0);

        // zero-length address probe
        a_addr[3] = 7'h5A; a_len[3] = 8'd0; req_rw[3] = 1'b0; req = 4'b1000;
        run_txn(rr_pick(req, mptr), 1'b0, 2, 1'b0, 1'b0, 1'b0);

        // core never completes
        a_addr[0] = 7'h10; req = 4'b0001; n = 0;
        while (gnt === 4'b0 && n < 30) begin @(negedge clk); n++; end
        check("wd_grant", 32'(gnt), 32'b0001);
        req = 4'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        n = 0;
        while (done === 4'b0 && n < 200) begin @(negedge clk); n++; end
        check("wd_abort", 32'(core_abort), 32'd1);
        check("wd_done_err", {24'd0, done, err}, {24'd0, 4'b0001, 4'b0001});
        check("wd_latency", 32'(n), 32'd101);
        mptr = 0; exp_dones++;
        @(negedge clk);
`else
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (gnt !== 4'b0001 || done !== 4'b0 || core_abort !== 1'b0) n++;
        end
        check("wd_hold", 32'(n), 32'd0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("wd_late_done", {24'd0, done, err}, {24'd0, 4'b0001, 4'b0000});
        mptr = 0; exp_dones++;
        @(negedge clk);
`endif

        // randomized transactions against the model
        for (int it = 0; it < 30; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                a_addr[i] = 7'($urandom); a_len[i] = 8'($urandom); req_rw[i] = 1'($urandom);
            end
            req = mask;
            run_txn(rr_pick(mask, mptr), 1'($urandom), int'($urandom_range(2, 12)),
                    1'($urandom), 1'($urandom), 1'b0);
        end

        check("onehot_grant", 32'(onehot_viol), 32'd0);
        check("done_count", 32'(done_seen), 32'(exp_dones));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
